// File: rtl/register_file.sv
// Multi-ported register file: two combinational read ports and one synchronous write port.
// Optional write-through bypass on the read ports is enabled by defining REGFILE_BYPASS_EN.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_REGS = 32
) (
    input  logic              clk_cpu,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_adrs_a,
    input  logic [ADDR_W-1:0] rd_adrs_b,
    input  logic [ADDR_W-1:0] wr_adrs,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic [DATA_W-1:0] q_a,
    output logic [DATA_W-1:0] q_b
);

    // One bit wider than an address so that N_REGS == 2**ADDR_W stays representable.
    localparam logic [ADDR_W:0] N_REGS_LIM = (ADDR_W + 1)'(N_REGS);

    logic [DATA_W-1:0] regs [N_REGS];
    logic              wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_adrs} < N_REGS_LIM);

    // NOTE: the array is reset element by element because every register must read
    // back as zero after reset; this rules out mapping it onto a plain RAM macro.
    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            // NOTE: non-blocking assignment keeps same-edge reads seeing the old contents.
            regs[wr_adrs] <= wr_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] adrs);
        logic [DATA_W-1:0] rdata;
        // NOTE: default first, so no path through this logic leaves rdata unassigned (no latch).
        rdata = '0;
        if (reset && ({1'b0, adrs} < N_REGS_LIM)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (adrs == wr_adrs)) begin
                rdata = wr_data;
            end else begin
                rdata = regs[adrs];
            end
`else
            rdata = regs[adrs];
`endif
        end
        return rdata;
    endfunction

    always_comb begin
        q_a = read_port(rd_adrs_a);
    end

    always_comb begin
        q_b = read_port(rd_adrs_b);
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a reference model feeds a queue of expected read
// values that are popped and compared against q_a/q_b once the read has settled.
module tb_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int N_REGS = 32;

    logic              clk_cpu;
    logic              reset;
    logic [ADDR_W-1:0] rd_adrs_a;
    logic [ADDR_W-1:0] rd_adrs_b;
    logic [ADDR_W-1:0] wr_adrs;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [DATA_W-1:0] q_a;
    logic [DATA_W-1:0] q_b;

    logic [DATA_W-1:0] model [N_REGS];
    logic [DATA_W-1:0] exp_q [$];
    int tests_run;
    int tests_failed;

    register_file #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .N_REGS(N_REGS)
    ) dut (
        .clk_cpu  (clk_cpu),
        .reset    (reset),
        .rd_adrs_a(rd_adrs_a),
        .rd_adrs_b(rd_adrs_b),
        .wr_adrs  (wr_adrs),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .q_a      (q_a),
        .q_b      (q_b)
    );

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N_REGS; i++) model[i] = '0;
    endtask

    // Queue the model's view of both ports, present the addresses, then pop and compare.
    task automatic read_pair(input string tag, input int a, input int b);
        exp_q.push_back(model[a]);
        exp_q.push_back(model[b]);
        rd_adrs_a = ADDR_W'(a);
        rd_adrs_b = ADDR_W'(b);
        #1;
        check($sformatf("%s_a[%0d]", tag, a), q_a, exp_q.pop_front());
        check($sformatf("%s_b[%0d]", tag, b), q_b, exp_q.pop_front());
    endtask

    task automatic write_reg(input int adrs, input logic [DATA_W-1:0] data);
        @(negedge clk_cpu);
        wr_en   = 1'b1;
        wr_adrs = ADDR_W'(adrs);
        wr_data = data;
        @(posedge clk_cpu);
        #1;
        wr_en = 1'b0;
        model[adrs] = data;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < N_REGS; i++) read_pair(tag, i, N_REGS - 1 - i);
    endtask

    initial begin
        logic [DATA_W-1:0] rnd;
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_adrs   = '0;
        wr_data   = '0;
        rd_adrs_a = '0;
        rd_adrs_b = '0;
        clear_model();

        // Power-on reset, outputs must be zero while reset is held.
        #2 reset = 1'b0;
        repeat (3) @(posedge clk_cpu);
        #1;
        read_pair("in_reset", 0, 31);
        @(negedge clk_cpu);
        reset = 1'b1;
        read_pair("post_reset", 3, 17);

        // Sequential access: reg[i] = i, including register 0.
        for (int i = 0; i < N_REGS; i++) write_reg(i, DATA_W'(i));
        read_all("seq");

        // Reset clear: fill with nonzero data, hold reset for 5 cycles.
        for (int i = 0; i < N_REGS; i++) write_reg(i, 32'hA5000000 | DATA_W'(i + 1));
        read_all("fill");
        @(negedge clk_cpu);
        reset = 1'b0;
        repeat (5) @(posedge clk_cpu);
        @(negedge clk_cpu);
        reset = 1'b1;
        clear_model();
        read_all("rst_clear");

        // Parallel access: write address i while reading address i-1 on both ports.
        for (int i = 0; i <= N_REGS; i++) begin
            rnd = $urandom();
            @(negedge clk_cpu);
            wr_en   = 1'b1;
            wr_adrs = ADDR_W'(i % N_REGS);
            wr_data = rnd;
            if (i > 0) read_pair("par", i - 1, i - 1);
            @(posedge clk_cpu);
            #1;
            wr_en = 1'b0;
            model[i % N_REGS] = rnd;
        end
        read_pair("par_end", 0, 31);

        // Write disable: reg 5 must keep its value.
        @(negedge clk_cpu);
        wr_en   = 1'b0;
        wr_adrs = 5'd5;
        wr_data = 32'hDEADBEEF;
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        read_pair("wr_dis", 5, 5);

        // Same-cycle read of the register being written.
        @(negedge clk_cpu);
        wr_en     = 1'b1;
        wr_adrs   = 5'd7;
        wr_data   = 32'h12345678;
        rd_adrs_a = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'h12345678);
`else
        exp_q.push_back(model[7]);
`endif
        check("same_cycle_q_a", q_a, exp_q.pop_front());
        @(posedge clk_cpu);
        #1;
        wr_en = 1'b0;
        model[7] = 32'h12345678;
        read_pair("after_edge", 7, 7);

        // Async reset pulse entirely between two rising edges.
        @(negedge clk_cpu);
        #1 reset = 1'b0;
        #1;
        clear_model();
        read_pair("async_low", 7, 5);
        #1 reset = 1'b1;
        read_all("async_clear");

        // Writes while reset is low are ignored.
        @(negedge clk_cpu);
        reset   = 1'b0;
        wr_en   = 1'b1;
        wr_adrs = 5'd9;
        wr_data = 32'hCAFEF00D;
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        wr_en = 1'b0;
        reset = 1'b1;
        read_pair("wr_in_reset", 9, 9);

        // First write after reset release takes effect on the next edge.
        write_reg(9, 32'h0BADC0DE);
        read_pair("first_wr", 9, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
